// File: rtl/ps2_key_uart_tx.sv
// PS/2 key-press events to 8N1 UART.
// Each new press is queued in a small FIFO and shifted out LSB first.
module ps2_key_uart_tx #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int DEPTH      = 8,
  parameter bit CHARS_ONLY = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               ps2_byte,
  input  logic                     ps2_state,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t         state_q, state_d;
  logic           state_r_q, state_r_d;
  logic [7:0]     byte_r_q, byte_r_d;
  logic [CW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     mem_q [DEPTH];

  logic ev, in_range, push, pop;
  logic full, wr_en, baud_end;

  // A press, or a different key replacing a held one
  assign ev       = ps2_state & (~state_r_q | (ps2_byte != byte_r_q));
  assign in_range = (ps2_byte >= 8'h41) && (ps2_byte <= 8'h5A);
  assign push     = ev & (~CHARS_ONLY | in_range);
  assign full     = (level_q == LW'(DEPTH));
  assign wr_en    = push & (~full | pop);
  assign baud_end = (baud_q == CW'(DIV - 1));

  always_comb begin
    state_r_d = ps2_state;
    byte_r_d  = ps2_byte;
    wr_ptr_d  = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    if (wr_en && !pop)
      level_d = level_q + LW'(1);
    else if (pop && !wr_en)
      level_d = level_q - LW'(1);
    ovf_d = ovf_q | (push & full & ~pop);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (level_q != '0) state_d = START;
      START: if (baud_end) state_d = DATA;
      DATA:  if (baud_end && bit_q == 3'd7)
               state_d = STOP;
      STOP:  if (baud_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    txd_d   = txd_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        if (level_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = 3'd0;
          txd_d  = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud_end) baud_d = '0;
        else baud_d = baud_q + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      state_r_q <= 1'b0;
      byte_r_q  <= 8'h00;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
      txd_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      state_r_q <= state_r_d;
      byte_r_q  <= byte_r_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= ps2_byte;
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_level = level_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_uart_tx.sv
// Directed bench for ps2_key_uart_tx: default instance plus a
// fast CHARS_ONLY=0 instance for the filter case.
module tb_ps2_key_uart_tx;

  localparam int DIV  = 434;
  localparam int DIV2 = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ps2_byte;
  logic       ps2_state;
  logic       uart_txd;
  logic       tx_busy;
  logic [3:0] fifo_level;
  logic       overflow;

  logic [7:0] b2;
  logic       s2;
  logic       txd2;
  logic       busy2;
  logic [3:0] lvl2;
  logic       ovf2;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ps2_key_uart_tx dut (
    .clk(clk), .rst(rst),
    .ps2_byte(ps2_byte), .ps2_state(ps2_state),
    .uart_txd(uart_txd), .tx_busy(tx_busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  ps2_key_uart_tx #(
    .CLK_FREQ(1000), .BAUD(100),
    .DEPTH(8), .CHARS_ONLY(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .ps2_byte(b2), .ps2_state(s2),
    .uart_txd(txd2), .tx_busy(busy2),
    .fifo_level(lvl2), .overflow(ovf2)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycle-exact frame check from frame cycle c0 to the stop-bit end
  task automatic frame_check(input string tag, input bit sel,
                             input logic [7:0] b, input int c0);
    int d;
    int errs;
    int k;
    logic e;
    d = sel ? DIV2 : DIV;
    errs = 0;
    for (int c = c0; c < 10 * d; c++) begin
      k = c / d;
      if (k == 0) e = 1'b0;
      else if (k == 9) e = 1'b1;
      else e = b[k-1];
      if ((sel ? txd2 : uart_txd) !== e) errs++;
      if ((sel ? busy2 : tx_busy) !== 1'b1) errs++;
      tick();
    end
    check(tag, errs, 0);
    check({tag, "_busy_end"}, sel ? busy2 : tx_busy, 0);
  endtask

  task automatic quiet(input string tag, input bit sel,
                       input int n);
    int errs;
    errs = 0;
    for (int c = 0; c < n; c++) begin
      if ((sel ? txd2 : uart_txd) !== 1'b1) errs++;
      if ((sel ? busy2 : tx_busy) !== 1'b0) errs++;
      tick();
    end
    check(tag, errs, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bv;

    // Reset with toggling inputs
    rst = 1'b1;
    ps2_state = 1'b0; ps2_byte = 8'h00;
    s2 = 1'b0; b2 = 8'h00;
    tick();
    ps2_state = 1'b1; ps2_byte = 8'h41;
    tick();
    ps2_state = 1'b0; ps2_byte = 8'h00;
    tick();
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    quiet("rst_quiet", 0, 50);
    check("rst_level_after", fifo_level, 0);

    // Single press of 'A'
    ps2_byte = 8'h41; ps2_state = 1'b1;
    tick();
    check("a_level_push", fifo_level, 1);
    check("a_txd_before", uart_txd, 1);
    check("a_busy_before", tx_busy, 0);
    tick();
    check("a_txd_start", uart_txd, 0);
    check("a_level_pop", fifo_level, 0);
    frame_check("frame_a", 0, 8'h41, 0);
    check("a_txd_after", uart_txd, 1);
    quiet("a_held_quiet", 0, 600);
    ps2_state = 1'b0;
    quiet("a_release_quiet", 0, 20);

    // Key change while held: 'Q' then 'W'
    ps2_byte = 8'h51; ps2_state = 1'b1;
    fork
      begin
        tick(100);
        ps2_byte = 8'h57;
      end
    join_none
    tick();
    tick();
    check("q_start", uart_txd, 0);
    frame_check("frame_q", 0, 8'h51, 0);
    check("w_queued", fifo_level, 1);
    check("qw_gap_idle", uart_txd, 1);
    tick();
    check("w_start", uart_txd, 0);
    frame_check("frame_w", 0, 8'h57, 0);
    ps2_state = 1'b0;
    quiet("qw_release_quiet", 0, 100);
    check("qw_level_end", fifo_level, 0);

    // Filter: '1' dropped by CHARS_ONLY=1, sent by CHARS_ONLY=0
    ps2_byte = 8'h31; ps2_state = 1'b1;
    b2 = 8'h31; s2 = 1'b1;
    tick();
    check("filt_level_on", fifo_level, 0);
    check("filt_level_off", lvl2, 1);
    tick();
    check("filt_start_off", txd2, 0);
    frame_check("frame_31", 1, 8'h31, 0);
    check("filt_level_on_end", fifo_level, 0);
    quiet("filt_quiet_on", 0, 20);
    ps2_state = 1'b0; s2 = 1'b0;
    tick();

    // Overflow: 'A'..'J' on consecutive edges
    ps2_state = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bv = 8'h41 + i[7:0];
      ps2_byte = bv;
      tick();
      if (i == 0) check("ovf_level_first", fifo_level, 1);
      if (i == 1) check("ovf_start_a", uart_txd, 0);
      if (i == 8) begin
        check("ovf_level_full", fifo_level, 8);
        check("ovf_not_yet", overflow, 0);
      end
      if (i == 9) begin
        check("ovf_level_hold", fifo_level, 8);
        check("ovf_set", overflow, 1);
      end
    end
    ps2_state = 1'b0;
    frame_check("ovf_frame_a", 0, 8'h41, 8);
    for (int j = 1; j < 9; j++) begin
      bv = 8'h41 + j[7:0];
      check("ovf_gap", uart_txd, 1);
      tick();
      check("ovf_start", uart_txd, 0);
      frame_check("ovf_frame", 0, bv, 0);
    end
    check("ovf_sticky", overflow, 1);
    check("ovf_level_end", fifo_level, 0);
    quiet("ovf_no_j", 0, 100);

    // Reset during DATA bit 3 with 3 bytes queued
    ps2_state = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bv = 8'h41 + i[7:0];
      ps2_byte = bv;
      tick();
    end
    ps2_state = 1'b0;
    check("mid_level_queued", fifo_level, 3);
    tick(1898);
    check("mid_bit3_low", uart_txd, 0);
    check("mid_busy", tx_busy, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_txd", uart_txd, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", overflow, 0);
    rst = 1'b0;
    quiet("mid_no_frames", 0, 1000);
    check("mid_level_end", fifo_level, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ps2_key_uart_tx.md
Name: ps2_key_uart_tx

Overview:
Downstream consumer of the PS/2 keyboard scanner. It takes the scanner's ASCII key value and its key-pressed state, and turns each new key press into a one-byte event. Events are buffered in a small FIFO and sent out as 8N1 UART frames, for PC-side logging and debug of the keyboard path.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; divider DIV = CLK_FREQ/BAUD (integer floor; 434 at defaults)
DEPTH, 8, FIFO depth in bytes; must be a power of 2, minimum 2
CHARS_ONLY, 1, 1 = push only bytes 8'h41..8'h5A ('A'..'Z'); 0 = push any byte

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous reset, active-high
ps2_byte  input  8  ASCII key value from the scanner; valid while ps2_state=1
ps2_state  input  1  1 = a key is currently held (scanner state)
uart_txd  output  1  UART serial output; idles high
tx_busy  output  1  1 while a frame is being shifted (any state other than IDLE)
fifo_level  output  clog2(DEPTH)+1  bytes currently buffered
overflow  output  1  sticky: set when an event is dropped because the FIFO is full

Behaviour:
- Single clock domain. Inputs come from logic on the same clk; no synchronizers.
- Reset is sampled on a clk edge. At that edge:
  - uart_txd=1, tx_busy=0, fifo_level=0, overflow=0.
  - FSM returns to IDLE; all counters are cleared.
  - Registered copies are cleared: state_r=0, byte_r=8'h00.
  - Reset mid-frame aborts the frame: txd returns high on that edge and the FIFO contents are discarded.
- Event detect uses state_r and byte_r, the registered copies of ps2_state and ps2_byte.
  - ev = ps2_state & (~state_r | (ps2_byte != byte_r)).
  - This covers a new press, and a new key that replaces a held key while ps2_state stays 1.
  - The push qualifier is ev & (CHARS_ONLY ? ps2_byte in 8'h41..8'h5A : 1).
  - Release (ps2_state 1->0) and a held, unchanged key generate nothing.
- FIFO write happens on the same edge at which ev is evaluated true, with data = ps2_byte.
  - If fifo_level==DEPTH and there is no pop on that edge, the byte is dropped and overflow is set on that edge.
  - A simultaneous push and pop while full is accepted; fifo_level stays at DEPTH.
  - Read and write pointers wrap modulo DEPTH.
  - fifo_level increments on push only, decrements on pop only, and is unchanged on push+pop.
- TX FSM (IDLE, START, DATA, STOP); baud counter counts 0..DIV-1.
  - IDLE: txd=1. If fifo_level!=0: pop the head into shift_r, txd<=0, go to START. This is the only pop point.
  - START: hold txd=0 for DIV cycles, then txd<=shift_r[0], bit_cnt<=0, go to DATA.
  - DATA: each bit lasts DIV cycles, LSB first. After bit 7: txd<=1, go to STOP.
  - STOP: hold txd=1 for DIV cycles, then go to IDLE.
- Timing:
  - Frame length is 10*DIV cycles from the txd falling edge to the end of the stop bit.
  - Back-to-back frames have exactly 1 IDLE cycle between the stop bit and the next start bit.
  - Latency: if the push occurs at edge k with the FIFO empty and the FSM in IDLE, txd goes low at edge k+1.
- tx_busy = (state != IDLE), registered.
- overflow clears only on rst.

Test Plan:
- Reset: hold rst=1 for 3 cycles while toggling inputs -> uart_txd=1, tx_busy=0, fifo_level=0, overflow=0, and nothing is transmitted after release.
- Single press: ps2_byte=8'h41, ps2_state 0->1 at edge k, held 5000 cycles -> fifo_level=1 after edge k; txd low after edge k+1 for 434 cycles; data bits 1,0,0,0,0,0,1,0; stop high; exactly one frame; tx_busy high for 4340 cycles.
- Key change while held: ps2_state=1, ps2_byte 8'h51 then 8'h57 (100 cycles apart) -> two frames, 'Q' then 'W', separated by 1 idle cycle; releasing to ps2_state=0 adds no frame.
- Filter: CHARS_ONLY=1, press with ps2_byte=8'h31 -> no push, fifo_level stays 0. With CHARS_ONLY=0 -> one frame carrying 8'h31.
- Overflow: 10 distinct presses ('A'..'J') within 200 cycles, DEPTH=8 -> the first byte is popped into TX, the next 8 are buffered (fifo_level=8), the last is dropped, overflow=1; the output stream is 'A'..'I' in order.
- Reset mid-frame: assert rst during DATA bit 3 with 3 bytes queued -> txd=1 on that edge, fifo_level=0, and no further frames are sent.
